rx_word_sr: RTL and testbench



---
 rtl/rx_sr_pkg.sv | 23 ++
 rtl/rx_bit_ctr.sv | 49 ++++
 rtl/rx_word_sr.sv | 194 +++++++++++++++++++
 tb/tb_rx_word_sr.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sr_pkg.sv
// ---------------------------------------------------------------------------
// rx_sr_pkg
//   Shared types and helpers for the receive word shift register.
//   - rx_state_t   : receiver FSM states (IDLE, SHIFT, PARITY)
//   - RX_DEFAULT_W : default word width
//   - cnt_width()  : width of a counter able to hold 0..data_w
//   PARITY is only reachable when RX_SR_PARITY_EN is defined.
// ---------------------------------------------------------------------------
package rx_sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam int RX_DEFAULT_W = 8;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/rx_bit_ctr.sv
// ---------------------------------------------------------------------------
// rx_bit_ctr
//   Wrapping up-counter: counts 0..MAX_VAL on en, then wraps to 0.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset
//     clr  in   synchronous clear to 0 (wins over en)
//     en   in   advance the count by one
//     cnt  out  current count
//     tc   out  terminal count (cnt == MAX_VAL)
// ---------------------------------------------------------------------------
module rx_bit_ctr #(
    parameter int MAX_VAL = 7,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc  = (cnt_q == CNT_W'(MAX_VAL));
    assign cnt = cnt_q;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_word_sr.sv
// ---------------------------------------------------------------------------
// rx_word_sr
//   Receive shift register: shifts serial_in on qualified sample strobes,
//   frames DATA_W-bit words and hands them to a consumer through a one-deep
//   valid/ready output buffer. Flags overrun when a completed word finds the
//   buffer full. Optional build macro RX_SR_PARITY_EN adds a trailing parity
//   bit check (parameter PARITY_ODD selects odd parity).
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     serial_in      synchronised serial data bit
//     sample_strobe  one-cycle pulse: sample serial_in now
//     rx_enable      frame active; low aborts and idles the receiver
//     clear          soft clear of framing, valid and error state
//     rx_ready       consumer accepts rx_word this cycle
//     sr_data        live shift-register contents
//     rx_word        buffered completed word
//     rx_valid       rx_word holds an unconsumed word
//     bit_cnt        bits received in the current word
//     overrun        sticky: completed word dropped, buffer full
//     parity_err     sticky parity error (0 without RX_SR_PARITY_EN)
// ---------------------------------------------------------------------------
module rx_word_sr
    import rx_sr_pkg::*;
#(
    parameter int DATA_W    = RX_DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
`ifdef RX_SR_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         serial_in,
    input  logic                         sample_strobe,
    input  logic                         rx_enable,
    input  logic                         clear,
    input  logic                         rx_ready,
    output logic [DATA_W-1:0]            sr_data,
    output logic [DATA_W-1:0]            rx_word,
    output logic                         rx_valid,
    output logic [cnt_width(DATA_W)-1:0] bit_cnt,
    output logic                         overrun,
    output logic                         parity_err
);

    localparam int CNT_W = cnt_width(DATA_W);
`ifdef RX_SR_PARITY_EN
    // Counter parks at DATA_W while waiting for the parity bit.
    localparam int CNT_MAX = DATA_W;
`else
    localparam int CNT_MAX = DATA_W - 1;
`endif

    rx_state_t   state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] sr_shifted;
    logic [DATA_W-1:0] done_word;
    logic              strobe_ok;
    logic              data_shift;
    logic              last_data;
    logic              word_done;
    logic              ctr_clr;
    logic              ctr_tc;

    // Strobes only count once the FSM has left IDLE, so a strobe coinciding
    // with rx_enable rising is ignored; clear outranks sampling.
    assign strobe_ok  = rx_enable & sample_strobe & ~clear & (state_q != IDLE);
    assign data_shift = strobe_ok & (state_q == SHIFT);
    assign ctr_clr    = clear | ~rx_enable;

    rx_bit_ctr #(
        .MAX_VAL (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_bit_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (strobe_ok),
        .cnt (bit_cnt),
        .tc  (ctr_tc)
    );

    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[DATA_W-2:0], serial_in};
        end else begin
            sr_shifted = {serial_in, sr_q[DATA_W-1:1]};
        end
    end

`ifdef RX_SR_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic parity_bad;

    // The word completes on the parity strobe; the parity bit itself never
    // enters the shift register.
    assign last_data  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign word_done  = strobe_ok & (state_q == PARITY) & ctr_tc;
    assign done_word  = sr_q;
    assign parity_bad = serial_in != ((^sr_q) ^ PARITY_ODD);

    always_comb begin
        parity_err_d = parity_err_q;
        if (clear) begin
            parity_err_d = 1'b0;
        end else if (word_done && parity_bad) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    // Completed value includes the bit being shifted in this cycle.
    assign last_data  = ctr_tc;
    assign word_done  = data_shift & last_data;
    assign done_word  = sr_shifted;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = rx_enable ? SHIFT : IDLE;
        end else if (!rx_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = SHIFT;
`ifdef RX_SR_PARITY_EN
                SHIFT:  if (data_shift && last_data) state_d = PARITY;
`else
                SHIFT:  state_d = SHIFT;
`endif
                PARITY: if (word_done) state_d = SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sr_d       = data_shift ? sr_shifted : sr_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (clear) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end else if (word_done) begin
            // A consumer draining the buffer on the completion edge frees it.
            if (!rx_valid_q || rx_ready) begin
                rx_word_d  = done_word;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sr_data  = sr_q;
    assign rx_word  = rx_word_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_word_sr.sv
// ---------------------------------------------------------------------------
// tb_rx_word_sr
//   Two DUT instances share the input stimulus: an 8-bit MSB-first receiver
//   and a 12-bit LSB-first receiver. A reference model (bit arrays and plain
//   arithmetic) is compared against both every cycle; directed sequences add
//   fixed expected values for the key corner cases.
// ---------------------------------------------------------------------------
module tb_rx_word_sr;

`ifdef RX_SR_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, serial_in, sample_strobe, rx_enable, clear, rx_ready;

    logic [7:0]  sr8, word8;
    logic        valid8, ovr8, perr8;
    logic [3:0]  cnt8;
    logic [11:0] sr12, word12;
    logic        valid12, ovr12, perr12;
    logic [3:0]  cnt12;

    rx_word_sr #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .sample_strobe (sample_strobe),
        .rx_enable     (rx_enable),
        .clear         (clear),
        .rx_ready      (rx_ready),
        .sr_data       (sr8),
        .rx_word       (word8),
        .rx_valid      (valid8),
        .bit_cnt       (cnt8),
        .overrun       (ovr8),
        .parity_err    (perr8)
    );

    rx_word_sr #(.DATA_W(12), .MSB_FIRST(1'b0)) u_dut12 (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .sample_strobe (sample_strobe),
        .rx_enable     (rx_enable),
        .clear         (clear),
        .rx_ready      (rx_ready),
        .sr_data       (sr12),
        .rx_word       (word12),
        .rx_valid      (valid12),
        .bit_cnt       (cnt12),
        .overrun       (ovr12),
        .parity_err    (perr12)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          mw   [2];
    bit          mmsb [2];
    int          mcnt [2];
    bit          mbits[2][0:31];
    logic [31:0] msr  [2];
    logic [31:0] mword[2];
    bit          mvalid[2], movr[2], mperr[2], marmed[2];

    function automatic logic [31:0] assemble(input int d);
        logic [31:0] w = '0;
        for (int i = 0; i < mw[d]; i++) begin
            if (mbits[d][i]) w = w | (32'd1 << (mmsb[d] ? (mw[d] - 1 - i) : i));
        end
        return w;
    endfunction

    function automatic bit data_xor(input int d);
        bit x = 1'b0;
        for (int i = 0; i < mw[d]; i++) x = x ^ mbits[d][i];
        return x;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] mask = (32'd1 << mw[d]) - 32'd1;
            bit done = 1'b0;
            if (rst) begin
                mcnt[d] = 0; msr[d] = '0; mword[d] = '0;
                mvalid[d] = 0; movr[d] = 0; mperr[d] = 0; marmed[d] = 0;
            end else if (clear) begin
                mcnt[d] = 0; mvalid[d] = 0; movr[d] = 0; mperr[d] = 0;
                marmed[d] = rx_enable;
            end else if (!rx_enable) begin
                mcnt[d] = 0; marmed[d] = 0;
                if (mvalid[d] && rx_ready) mvalid[d] = 0;
            end else begin
                if (marmed[d] && sample_strobe) begin
                    if (mcnt[d] == mw[d]) begin
                        if (serial_in != data_xor(d)) mperr[d] = 1;
                        done = 1'b1;
                    end else begin
                        mbits[d][mcnt[d]] = serial_in;
                        mcnt[d]++;
                        if (mmsb[d]) msr[d] = ((msr[d] << 1) | 32'(serial_in)) & mask;
                        else         msr[d] = (msr[d] >> 1) | (32'(serial_in) << (mw[d] - 1));
                        if (mcnt[d] == mw[d] && !PAR) done = 1'b1;
                    end
                end
                if (done) begin
                    mcnt[d] = 0;
                    if (!mvalid[d] || rx_ready) begin
                        mword[d] = assemble(d);
                        mvalid[d] = 1;
                    end else begin
                        movr[d] = 1;
                    end
                end else if (mvalid[d] && rx_ready) begin
                    mvalid[d] = 0;
                end
                marmed[d] = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("d8_valid",  32'(valid8),  32'(mvalid[0]));
        check("d8_word",   32'(word8),   mword[0]);
        check("d8_cnt",    32'(cnt8),    32'(mcnt[0]));
        check("d8_ovr",    32'(ovr8),    32'(movr[0]));
        check("d8_perr",   32'(perr8),   32'(mperr[0]));
        check("d8_sr",     32'(sr8),     msr[0]);
        check("d12_valid", 32'(valid12), 32'(mvalid[1]));
        check("d12_word",  32'(word12),  mword[1]);
        check("d12_cnt",   32'(cnt12),   32'(mcnt[1]));
        check("d12_ovr",   32'(ovr12),   32'(movr[1]));
        check("d12_perr",  32'(perr12),  32'(mperr[1]));
        check("d12_sr",    32'(sr12),    msr[1]);
    endtask

    // Inputs are set right after the previous edge + 1, outputs checked at edge + 1.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_clear();
        clear = 1'b1; sample_strobe = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    // Sends a data word (plus parity bit in the parity build); rx_ready is
    // raised only on the completing strobe when rdy_last is set.
    task automatic send_frame(input logic [31:0] val, input int w, input bit msb,
                              input bit rdy_last, input bit par_good);
        logic [31:0] m;
        rx_enable = 1'b1;
        clear     = 1'b0;
        for (int i = 0; i < w; i++) begin
            serial_in     = msb ? val[w-1-i] : val[i];
            sample_strobe = 1'b1;
            rx_ready      = rdy_last && (i == w - 1) && !PAR;
            tick();
        end
        if (PAR) begin
            m = val & ((32'd1 << w) - 32'd1);
            serial_in     = (^m) ^ !par_good;
            sample_strobe = 1'b1;
            rx_ready      = rdy_last;
            tick();
        end
        sample_strobe = 1'b0;
        rx_ready      = 1'b0;
        serial_in     = 1'b0;
    endtask

    typedef struct {
        bit          en, stb, ser, rdy, clr;
        bit          ev;
        logic [31:0] ew;
        int          ec;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] a5 = 8'hA5;

        mw[0] = 8;  mmsb[0] = 1'b1;
        mw[1] = 12; mmsb[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; msr[d] = '0; mword[d] = '0;
            mvalid[d] = 0; movr[d] = 0; mperr[d] = 0; marmed[d] = 0;
        end

        // Table: enable with a simultaneous (ignored) strobe, then 8'hA5 MSB first.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0});
        for (int i = 0; i < 8; i++) begin
            tbl.push_back('{1'b1, 1'b1, a5[7-i], 1'b0, 1'b0,
                            (i == 7) && !PAR,
                            ((i == 7) && !PAR) ? 32'hA5 : 32'h0,
                            (i < 7) ? i + 1 : (PAR ? 8 : 0)});
        end
        if (PAR) tbl.push_back('{1'b1, 1'b1, ^a5, 1'b0, 1'b0, 1'b1, 32'hA5, 0});

        // ---- Test 1: reset with random inputs ----
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            serial_in     = 1'($urandom);
            sample_strobe = 1'($urandom);
            rx_enable     = 1'($urandom);
            clear         = 1'($urandom);
            rx_ready      = 1'($urandom);
            tick();
        end
        check("rst_word8",  32'(word8),  32'h0);
        check("rst_valid8", 32'(valid8), 32'h0);
        check("rst_cnt8",   32'(cnt8),   32'h0);
        check("rst_sr8",    32'(sr8),    32'h0);
        check("rst_ovr8",   32'(ovr8),   32'h0);
        check("rst_perr8",  32'(perr8),  32'h0);
        rst = 1'b0; clear = 1'b0; rx_ready = 1'b0;

        foreach (tbl[k]) begin
            rx_enable     = tbl[k].en;
            sample_strobe = tbl[k].stb;
            serial_in     = tbl[k].ser;
            rx_ready      = tbl[k].rdy;
            clear         = tbl[k].clr;
            tick();
            check("tbl_valid", 32'(valid8), 32'(tbl[k].ev));
            check("tbl_word",  32'(word8),  tbl[k].ew);
            check("tbl_cnt",   32'(cnt8),   32'(tbl[k].ec));
        end
        sample_strobe = 1'b0;

        // ---- Test 2: 12-bit LSB-first word ----
        do_clear();
        send_frame(32'h3C1, 12, 1'b0, 1'b0, 1'b1);
        check("lsb_word12",  32'(word12),  32'h3C1);
        check("lsb_valid12", 32'(valid12), 32'h1);

        // ---- Test 3: overrun then clear ----
        do_clear();
        send_frame(32'h11, 8, 1'b1, 1'b0, 1'b1);
        send_frame(32'h22, 8, 1'b1, 1'b0, 1'b1);
        check("ovr_word8",  32'(word8),  32'h11);
        check("ovr_flag8",  32'(ovr8),   32'h1);
        check("ovr_valid8", 32'(valid8), 32'h1);
        do_clear();
        check("clr_ovr8",   32'(ovr8),   32'h0);
        check("clr_valid8", 32'(valid8), 32'h0);

        // ---- Test 4: consume on the completion edge ----
        send_frame(32'h44, 8, 1'b1, 1'b0, 1'b1);
        send_frame(32'h33, 8, 1'b1, 1'b1, 1'b1);
        check("sim_word8",  32'(word8),  32'h33);
        check("sim_valid8", 32'(valid8), 32'h1);
        check("sim_ovr8",   32'(ovr8),   32'h0);

        // ---- Test 5: abort mid-word ----
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'b1; sample_strobe = 1'b1;
            tick();
        end
        sample_strobe = 1'b0;
        check("abt_cnt5", 32'(cnt8), 32'd5);
        rx_enable = 1'b0; rx_ready = 1'b1;
        tick();
        check("abt_cnt0",   32'(cnt8),   32'h0);
        check("abt_valid0", 32'(valid8), 32'h0);
        rx_ready = 1'b0; rx_enable = 1'b1;
        tick();
        send_frame(32'hF0, 8, 1'b1, 1'b0, 1'b1);
        check("abt_word8",  32'(word8),  32'hF0);
        check("abt_valid8", 32'(valid8), 32'h1);

`ifdef RX_SR_PARITY_EN
        // ---- Test 6: parity good then bad ----
        do_clear();
        send_frame(32'h07, 8, 1'b1, 1'b0, 1'b1);
        check("par_ok_perr",  32'(perr8),  32'h0);
        check("par_ok_word",  32'(word8),  32'h07);
        send_frame(32'h07, 8, 1'b1, 1'b1, 1'b0);
        check("par_bad_perr",  32'(perr8),  32'h1);
        check("par_bad_word",  32'(word8),  32'h07);
        check("par_bad_valid", 32'(valid8), 32'h1);
`endif

        // ---- Randomised traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            clear         = ($urandom_range(0, 59) == 0);
            rx_enable     = ($urandom_range(0, 24) != 0);
            sample_strobe = 1'($urandom);
            serial_in     = 1'($urandom);
            rx_ready      = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
